user_move_ctrl: RTL and testbench
=================================

USER_MOVE_CTRL -- requirements
Module: user_move_ctrl

Interface
REQ-001 SHALL have parameter X_INIT, default 150, meaning the x position loaded at reset.
REQ-002 SHALL have parameter Y_ROW, default 210, meaning the fixed y position of the user row.
REQ-003 SHALL have parameter X_MAX, default 300, meaning the largest legal x (320 minus 20-pixel sprite width).
REQ-004 SHALL have parameter STEP, default 2, meaning pixels moved per accepted frame.
REQ-005 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-006 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port frame_tick  input  1  one-cycle pulse per display frame.
REQ-008 SHALL have port move_left  input  1  level; left key held.
REQ-009 SHALL have port move_right  input  1  level; right key held.
REQ-010 SHALL have port plot_done  input  1  one-cycle pulse from the sprite plotter when a 400-pixel pass finishes.
REQ-011 SHALL have port plot_start  output  1  one-cycle pulse requesting a sprite pass; drives the plotter enable.
REQ-012 SHALL have port erase  output  1  high while the current pass must paint background (colour forced to 0 downstream).
REQ-013 SHALL have port x_pos  output  9  sprite top-left x; drives plotter initial x.
REQ-014 SHALL have port y_pos  output  8  sprite top-left y; constant Y_ROW.
REQ-015 SHALL have port busy  output  1  high in every state except S_IDLE.

Function
REQ-016 SHALL implement states S_INIT, S_IDLE, S_ERASE_REQ, S_ERASE_WAIT, S_UPDATE, S_DRAW_REQ, S_DRAW_WAIT.
REQ-017 S_INIT SHALL go to S_DRAW_REQ unconditionally one cycle after reset release, so the sprite is drawn once at power-up.
REQ-018 In S_IDLE, on frame_tick SHALL latch direction: left only -> LEFT, right only -> RIGHT, both or neither -> NONE.
REQ-019 In S_IDLE, frame_tick with NONE SHALL leave the FSM in S_IDLE with no plot request; LEFT/RIGHT SHALL go to S_ERASE_REQ next cycle.
REQ-020 S_ERASE_REQ SHALL assert plot_start for exactly one cycle and erase, then go to S_ERASE_WAIT.
REQ-021 S_ERASE_WAIT SHALL hold erase=1 and x_pos unchanged until plot_done, then go to S_UPDATE.
REQ-022 S_UPDATE SHALL update x_pos in one cycle, then go to S_DRAW_REQ.
REQ-023 LEFT update: x_pos < STEP -> 0, else x_pos - STEP; RIGHT update: x_pos > X_MAX - STEP -> X_MAX, else x_pos + STEP; 9-bit unsigned, never wraps.
REQ-024 S_DRAW_REQ SHALL assert plot_start for one cycle with erase=0, then go to S_DRAW_WAIT.
REQ-025 S_DRAW_WAIT SHALL hold until plot_done, then go to S_IDLE.
REQ-026 frame_tick outside S_IDLE SHALL be ignored (frame dropped, not queued).
REQ-027 plot_done outside the two WAIT states SHALL be ignored.
REQ-028 frame_tick and plot_done in the same cycle in S_DRAW_WAIT SHALL return to S_IDLE; the tick is dropped.
REQ-029 A move clamped to an unchanged x_pos SHALL still perform the full erase/draw sequence.
REQ-030 plot_start and erase SHALL be registered outputs (no combinational path from inputs).

Reset
REQ-031 resetn low SHALL immediately force: state S_INIT, x_pos=X_INIT, y_pos=Y_ROW, plot_start=0, erase=0, busy=1, direction NONE.
REQ-032 Reset mid-pass SHALL abandon the pass; the plotter is reset by the same resetn.

Verification
REQ-033 Reset release, plot_done 400 cycles after plot_start -> one plot_start with erase=0, x_pos=150, then busy=0.
REQ-034 Idle, move_right=1, frame_tick -> plot_start erase=1 at x=150, after plot_done x_pos=152, second plot_start erase=0, busy=0 after second plot_done.
REQ-035 x_pos=1, move_left, tick -> x_pos=0; repeat -> x_pos stays 0, erase/draw still issued; x_pos=299, move_right -> 300 (clamped).
REQ-036 Both keys held, frame_tick -> no plot_start, x_pos unchanged, busy stays 0.
REQ-037 frame_tick pulsed during S_ERASE_WAIT and together with final plot_done -> exactly one move (x changes by STEP once).
REQ-038 resetn asserted asynchronously mid S_ERASE_WAIT -> outputs return to reset values same cycle; redraw at x=150 after release.

Source files
------------

// File: rtl/user_move_ctrl.sv
// rtl/user_move_ctrl.sv - user sprite movement controller: erase, move, redraw per frame
module user_move_ctrl #(
  parameter int X_INIT = 150,
  parameter int Y_ROW  = 210,
  parameter int X_MAX  = 300,
  parameter int STEP   = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       frame_tick,
  input  logic       move_left,
  input  logic       move_right,
  input  logic       plot_done,
  output logic       plot_start,
  output logic       erase,
  output logic [8:0] x_pos,
  output logic [7:0] y_pos,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_ERASE_REQ,
    S_ERASE_WAIT,
    S_UPDATE,
    S_DRAW_REQ,
    S_DRAW_WAIT
  } state_t;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_LEFT,
    DIR_RIGHT
  } dir_t;

  localparam logic [8:0] X_INIT_W = 9'(X_INIT);
  localparam logic [8:0] X_MAX_W  = 9'(X_MAX);
  localparam logic [8:0] STEP_W   = 9'(STEP);
  // Largest x that can still take a full step right without passing X_MAX.
  localparam logic [8:0] X_LIM_W  = 9'(X_MAX - STEP);

  state_t     state_q, state_d;
  dir_t       dir_q, dir_d;
  dir_t       key_dir;
  logic [8:0] x_q, x_d;
  logic       plot_start_q, plot_start_d;
  logic       erase_q, erase_d;

  // Decode held keys into a single direction; opposing keys cancel out.
  always_comb begin
    key_dir = DIR_NONE;
    if (move_left && !move_right) begin
      key_dir = DIR_LEFT;
    end else if (move_right && !move_left) begin
      key_dir = DIR_RIGHT;
    end
  end

  // Next-state, latched direction and saturating position update.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    x_d     = x_q;
    case (state_q)
      S_INIT: begin
        state_d = S_DRAW_REQ;
      end
      S_IDLE: begin
        if (frame_tick) begin
          dir_d = key_dir;
          if (key_dir != DIR_NONE) begin
            state_d = S_ERASE_REQ;
          end
        end
      end
      S_ERASE_REQ: begin
        state_d = S_ERASE_WAIT;
      end
      S_ERASE_WAIT: begin
        if (plot_done) begin
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        if (dir_q == DIR_LEFT) begin
          x_d = (x_q < STEP_W) ? 9'd0 : x_q - STEP_W;
        end else if (dir_q == DIR_RIGHT) begin
          x_d = (x_q > X_LIM_W) ? X_MAX_W : x_q + STEP_W;
        end
        state_d = S_DRAW_REQ;
      end
      S_DRAW_REQ: begin
        state_d = S_DRAW_WAIT;
      end
      S_DRAW_WAIT: begin
        if (plot_done) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  // Plotter controls are decoded from the next state so they come straight off flops.
  always_comb begin
    plot_start_d = (state_d == S_ERASE_REQ) || (state_d == S_DRAW_REQ);
    erase_d      = (state_d == S_ERASE_REQ) || (state_d == S_ERASE_WAIT);
  end

  // State and output registers; reset abandons any pass in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_INIT;
      dir_q        <= DIR_NONE;
      x_q          <= X_INIT_W;
      plot_start_q <= 1'b0;
      erase_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      x_q          <= x_d;
      plot_start_q <= plot_start_d;
      erase_q      <= erase_d;
    end
  end

  assign plot_start = plot_start_q;
  assign erase      = erase_q;
  assign x_pos      = x_q;
  assign y_pos      = 8'(Y_ROW);
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_user_move_ctrl.sv
// tb/tb_user_move_ctrl.sv - randomized self-checking bench for user_move_ctrl
module tb_user_move_ctrl;

  localparam int X_INIT = 150;
  localparam int Y_ROW  = 210;
  localparam int X_MAX  = 300;
  localparam int STEP   = 2;

  logic       clk;
  logic       resetn;
  logic       frame_tick;
  logic       move_left;
  logic       move_right;
  logic       plot_done;
  logic       plot_start;
  logic       erase;
  logic [8:0] x_pos;
  logic [7:0] y_pos;
  logic       busy;

  int errors;
  int checks;
  int x_model;

  user_move_ctrl #(
    .X_INIT(X_INIT),
    .Y_ROW (Y_ROW),
    .X_MAX (X_MAX),
    .STEP  (STEP)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .frame_tick(frame_tick),
    .move_left (move_left),
    .move_right(move_right),
    .plot_done (plot_done),
    .plot_start(plot_start),
    .erase     (erase),
    .x_pos     (x_pos),
    .y_pos     (y_pos),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One full key-driven frame: expected position from the movement rules.
  task automatic do_move(input bit l, input bit r, input int lat1, input int lat2,
                         input bit tick_extra);
    int exp_x;
    bit found;
    if (l && !r) exp_x = (x_model < STEP) ? 0 : x_model - STEP;
    else if (r && !l) exp_x = (x_model > X_MAX - STEP) ? X_MAX : x_model + STEP;
    else exp_x = x_model;
    move_left  = l;
    move_right = r;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    if (l == r) begin
      found = 1'b0;
      repeat (6) begin
        if (plot_start) found = 1'b1;
        @(negedge clk);
      end
      checks++;
      if (found !== 1'b0 || busy !== 1'b0 || x_pos !== 9'(x_model)) begin
        errors++;
        $display("FAIL no_move: plot_start_seen=%0b busy=%0b x=%0d, required 0 0 %0d",
                 found, busy, x_pos, x_model);
      end
      return;
    end
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (plot_start) begin found = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!found || erase !== 1'b1 || x_pos !== 9'(x_model)) begin
      errors++;
      $display("FAIL erase_req: found=%0b erase=%0b x=%0d, required 1 1 %0d",
               found, erase, x_pos, x_model);
    end
    @(negedge clk);
    checks++;
    if (plot_start !== 1'b0 || erase !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL erase_wait: plot_start=%0b erase=%0b busy=%0b, required 0 1 1",
               plot_start, erase, busy);
    end
    if (tick_extra) begin
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
    end
    repeat (lat1) @(negedge clk);
    checks++;
    if (erase !== 1'b1 || x_pos !== 9'(x_model) || plot_start !== 1'b0) begin
      errors++;
      $display("FAIL erase_hold: erase=%0b x=%0d plot_start=%0b, required 1 %0d 0",
               erase, x_pos, plot_start, x_model);
    end
    plot_done = 1'b1;
    @(negedge clk);
    plot_done = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (plot_start) begin found = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!found || erase !== 1'b0 || x_pos !== 9'(exp_x)) begin
      errors++;
      $display("FAIL draw_req: found=%0b erase=%0b x=%0d, required 1 0 %0d",
               found, erase, x_pos, exp_x);
    end
    @(negedge clk);
    repeat (lat2) @(negedge clk);
    plot_done  = 1'b1;
    frame_tick = tick_extra;
    @(negedge clk);
    plot_done  = 1'b0;
    frame_tick = 1'b0;
    checks++;
    if (busy !== 1'b0 || x_pos !== 9'(exp_x)) begin
      errors++;
      $display("FAIL move_done: busy=%0b x=%0d, required 0 %0d", busy, x_pos, exp_x);
    end
    if (tick_extra) begin
      found = 1'b0;
      repeat (6) begin
        if (plot_start || busy) found = 1'b1;
        @(negedge clk);
      end
      checks++;
      if (found !== 1'b0 || x_pos !== 9'(exp_x)) begin
        errors++;
        $display("FAIL dropped_tick: activity=%0b x=%0d, required 0 %0d",
                 found, x_pos, exp_x);
      end
    end
    x_model = exp_x;
  endtask

  task automatic test_reset();
    bit found;
    resetn     = 1'b0;
    frame_tick = 1'b0;
    move_left  = 1'b0;
    move_right = 1'b0;
    plot_done  = 1'b0;
    x_model    = X_INIT;
    repeat (2) @(negedge clk);
    checks++;
    if (plot_start !== 1'b0 || erase !== 1'b0 || busy !== 1'b1 ||
        x_pos !== 9'(X_INIT) || y_pos !== 8'(Y_ROW)) begin
      errors++;
      $display("FAIL reset_vals: ps=%0b er=%0b busy=%0b x=%0d y=%0d, required 0 0 1 %0d %0d",
               plot_start, erase, busy, x_pos, y_pos, X_INIT, Y_ROW);
    end
    resetn = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (plot_start) begin found = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!found || erase !== 1'b0 || x_pos !== 9'(X_INIT)) begin
      errors++;
      $display("FAIL powerup_draw: found=%0b erase=%0b x=%0d, required 1 0 %0d",
               found, erase, x_pos, X_INIT);
    end
    @(negedge clk);
    checks++;
    if (plot_start !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL powerup_wait: plot_start=%0b busy=%0b, required 0 1", plot_start, busy);
    end
    repeat (398) @(negedge clk);
    plot_done = 1'b1;
    @(negedge clk);
    plot_done = 1'b0;
    checks++;
    if (busy !== 1'b0 || plot_start !== 1'b0) begin
      errors++;
      $display("FAIL powerup_idle: busy=%0b plot_start=%0b, required 0 0", busy, plot_start);
    end
  endtask

  task automatic test_done_ignored();
    bit act;
    plot_done = 1'b1;
    @(negedge clk);
    plot_done = 1'b0;
    act = 1'b0;
    repeat (4) begin
      if (plot_start || busy) act = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (act !== 1'b0) begin
      errors++;
      $display("FAIL idle_done_ignored: activity=%0b, required 0", act);
    end
  endtask

  task automatic test_basic_moves();
    do_move(1'b0, 1'b1, 3, 3, 1'b0);
    do_move(1'b1, 1'b1, 1, 1, 1'b0);
    do_move(1'b0, 1'b0, 1, 1, 1'b0);
    do_move(1'b1, 1'b0, 2, 4, 1'b0);
    do_move(1'b0, 1'b1, 4, 2, 1'b1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      do_move(1'($urandom), 1'($urandom), $urandom_range(1, 5),
              $urandom_range(1, 5), 1'($urandom));
    end
  endtask

  task automatic test_clamp();
    while (x_model > 0) do_move(1'b1, 1'b0, 1, 1, 1'b0);
    repeat (2) do_move(1'b1, 1'b0, $urandom_range(1, 3), 1, 1'b0);
    while (x_model < X_MAX) do_move(1'b0, 1'b1, 1, 1, 1'b0);
    repeat (2) do_move(1'b0, 1'b1, 1, $urandom_range(1, 3), 1'b0);
    do_move(1'b1, 1'b0, 1, 1, 1'b0);
  endtask

  task automatic test_async_reset();
    bit found;
    move_left  = 1'b0;
    move_right = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (erase !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_erase: erase=%0b busy=%0b, required 1 1", erase, busy);
    end
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (plot_start !== 1'b0 || erase !== 1'b0 || busy !== 1'b1 ||
        x_pos !== 9'(X_INIT) || y_pos !== 8'(Y_ROW)) begin
      errors++;
      $display("FAIL async_reset: ps=%0b er=%0b busy=%0b x=%0d y=%0d, required 0 0 1 %0d %0d",
               plot_start, erase, busy, x_pos, y_pos, X_INIT, Y_ROW);
    end
    move_right = 1'b0;
    @(negedge clk);
    resetn  = 1'b1;
    x_model = X_INIT;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (plot_start) begin found = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!found || erase !== 1'b0 || x_pos !== 9'(X_INIT)) begin
      errors++;
      $display("FAIL redraw_after_reset: found=%0b erase=%0b x=%0d, required 1 0 %0d",
               found, erase, x_pos, X_INIT);
    end
    @(negedge clk);
    repeat (5) @(negedge clk);
    plot_done = 1'b1;
    @(negedge clk);
    plot_done = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL redraw_idle: busy=%0b, required 0", busy);
    end
    do_move(1'b1, 1'b0, 2, 2, 1'b0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_done_ignored();
    test_basic_moves();
    test_random();
    test_clamp();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
